// File: rtl/ft245_cmd_rx_pkg.sv
// FT245 command receiver shared types: PHY/parser states and the byte bundle.
// CMD_RX_CHECKSUM_EN adds a trailing XOR checksum byte to each packet.
package ft245_cmd_rx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef CMD_RX_CHECKSUM_EN
  localparam int PKT_LEN = 7;
`else
  localparam int PKT_LEN = 6;
`endif

  typedef enum logic [1:0] {
    PHY_IDLE,
    PHY_STROBE,
    PHY_PRECH
  } phy_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_ADDR,
    P_D3,
    P_D2,
    P_D1,
    P_D0,
    P_CSUM,
    P_HOLD
  } prs_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rx_byte_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ft245_rd_phy.sv
// FT245 read PHY: RXF# synchronizer, RD# strobe/precharge timing,
// and a one-cycle byte strobe as RD# rises.
module ft245_rd_phy
  import ft245_cmd_rx_pkg::*;
#(
  parameter int RD_PULSE_CYC     = 4,
  parameter int RD_PRECHARGE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxf_n,
  input  logic [7:0] data_in,
  input  logic       bus_gnt,
  input  logic       accept,
  output logic       rd_n,
  output logic       busy,
  output rx_byte_t   rx_byte
);

  localparam logic [7:0] PULSE_LAST = 8'(RD_PULSE_CYC - 1);
  localparam logic [7:0] PRE_LAST   = 8'(RD_PRECHARGE_CYC - 1);

  phy_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       rxf_s1, rxf_s2;
  logic       last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 8'd1;
    last      = 1'b0;
    unique case (state)
      PHY_IDLE: begin
        cnt_nxt = '0;
        if (!rxf_s2 && bus_gnt && accept)
          state_nxt = PHY_STROBE;
      end
      PHY_STROBE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = PHY_PRECH;
          cnt_nxt   = '0;
          last      = 1'b1;
        end
      end
      PHY_PRECH: begin
        if (cnt == PRE_LAST) begin
          state_nxt = PHY_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = PHY_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // RD#/busy are registered from the next state so the pins never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_s1       <= 1'b1;
      rxf_s2       <= 1'b1;
      state        <= PHY_IDLE;
      cnt          <= '0;
      rd_n         <= 1'b1;
      busy         <= 1'b0;
      rx_byte.vld  <= 1'b0;
      rx_byte.data <= '0;
    end else begin
      rxf_s1      <= rxf_n;
      rxf_s2      <= rxf_s1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rd_n        <= (state_nxt != PHY_STROBE);
      busy        <= (state_nxt != PHY_IDLE);
      rx_byte.vld <= last;
      if (last)
        rx_byte.data <= data_in;
    end
  end

endmodule

// File: rtl/ft245_cmd_rx.sv
// FT245 host command receiver: frames RD bytes into (addr, data) writes.
// Define CMD_RX_CHECKSUM_EN to require and verify a trailing XOR checksum.
module ft245_cmd_rx
  import ft245_cmd_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEF,
  parameter int         RD_PULSE_CYC     = 4,
  parameter int         RD_PRECHARGE_CYC = 2,
  parameter int         TIMEOUT_CYC      = 80000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXF,
  input  logic [7:0]  DATA_IN,
  output logic        RD,
  input  logic        BUS_GNT,
  output logic        BUS_BUSY,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [7:0]  CMD_ADDR,
  output logic [31:0] CMD_DATA,
  output logic [7:0]  ERR_CNT
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  rx_byte_t      rx;
  prs_state_t    st, st_nxt;
  logic [7:0]    addr_q;
  logic [31:8]   data_hi;
  logic [TW-1:0] to_cnt;
  logic          in_pkt;
  logic          to_hit;
  logic          err_inc;
  logic          load_cmd;
  logic          accept;
`ifdef CMD_RX_CHECKSUM_EN
  logic [7:0]    data_lo;
  logic [7:0]    csum_q;
`endif

  assign accept = (st != P_HOLD);
  assign in_pkt = (st != P_HUNT) && (st != P_HOLD);
  assign to_hit = in_pkt && !rx.vld && (to_cnt == TO_LAST);

  ft245_rd_phy #(
    .RD_PULSE_CYC    (RD_PULSE_CYC),
    .RD_PRECHARGE_CYC(RD_PRECHARGE_CYC)
  ) u_phy (
    .clk    (CLK),
    .rst_n  (RST),
    .rxf_n  (RXF),
    .data_in(DATA_IN),
    .bus_gnt(BUS_GNT),
    .accept (accept),
    .rd_n   (RD),
    .busy   (BUS_BUSY),
    .rx_byte(rx)
  );

  always_comb begin
    st_nxt   = st;
    err_inc  = 1'b0;
    load_cmd = 1'b0;
    unique case (st)
      P_HUNT: if (rx.vld && rx.data == SYNC_BYTE) st_nxt = P_ADDR;
      P_ADDR: if (rx.vld) st_nxt = P_D3;
      P_D3:   if (rx.vld) st_nxt = P_D2;
      P_D2:   if (rx.vld) st_nxt = P_D1;
      P_D1:   if (rx.vld) st_nxt = P_D0;
      P_D0: begin
        if (rx.vld) begin
`ifdef CMD_RX_CHECKSUM_EN
          st_nxt = P_CSUM;
`else
          st_nxt   = P_HOLD;
          load_cmd = 1'b1;
`endif
        end
      end
`ifdef CMD_RX_CHECKSUM_EN
      P_CSUM: begin
        if (rx.vld) begin
          if (rx.data == csum_q) begin
            st_nxt   = P_HOLD;
            load_cmd = 1'b1;
          end else begin
            st_nxt  = P_HUNT;
            err_inc = 1'b1;
          end
        end
      end
`endif
      P_HOLD: if (CMD_READY) st_nxt = P_HUNT;
      default: st_nxt = P_HUNT;
    endcase
    // a stalled host abandons the partial packet
    if (to_hit) begin
      st_nxt  = P_HUNT;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= P_HUNT;
      to_cnt    <= '0;
      addr_q    <= '0;
      data_hi   <= '0;
      CMD_VALID <= 1'b0;
      CMD_ADDR  <= '0;
      CMD_DATA  <= '0;
      ERR_CNT   <= '0;
    end else begin
      st        <= st_nxt;
      CMD_VALID <= (st_nxt == P_HOLD);
      if (!in_pkt || rx.vld)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (rx.vld) begin
        if (st == P_ADDR) addr_q          <= rx.data;
        if (st == P_D3)   data_hi[31:24]  <= rx.data;
        if (st == P_D2)   data_hi[23:16]  <= rx.data;
        if (st == P_D1)   data_hi[15:8]   <= rx.data;
      end
      if (load_cmd) begin
        CMD_ADDR <= addr_q;
`ifdef CMD_RX_CHECKSUM_EN
        CMD_DATA <= {data_hi, data_lo};
`else
        CMD_DATA <= {data_hi, rx.data};
`endif
      end
      if (err_inc)
        ERR_CNT <= sat_inc(ERR_CNT);
    end
  end

`ifdef CMD_RX_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_lo <= '0;
      csum_q  <= '0;
    end else if (rx.vld) begin
      if (st == P_D0)
        data_lo <= rx.data;
      if (st == P_ADDR)
        csum_q <= rx.data;
      else if (st == P_D3 || st == P_D2 || st == P_D1 || st == P_D0)
        csum_q <= csum_q ^ rx.data;
    end
  end
`endif

endmodule

// File: tb/tb_ft245_cmd_rx.sv
// Bench for ft245_cmd_rx: FT245 host model feeding byte streams, packet-level
// reference model predicting commands and error count.
module tb_ft245_cmd_rx;

  localparam int TO = 400;
`ifdef CMD_RX_CHECKSUM_EN
  localparam int PLEN = 7;
`else
  localparam int PLEN = 6;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        RXF;
  logic [7:0]  DATA_IN;
  logic        RD;
  logic        BUS_GNT;
  logic        BUS_BUSY;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [7:0]  CMD_ADDR;
  logic [31:0] CMD_DATA;
  logic [7:0]  ERR_CNT;

  int n_chk = 0;
  int n_fail = 0;
  int m_err = 0;
  int n_reads = 0;
  logic [7:0]  host_q[$];
  logic [7:0]  m_pkt[$];
  logic [39:0] exp_q[$];
  logic        in_rd = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        ready_lvl = 1'b1;
  logic        hold_seen = 1'b0;
  logic [39:0] hold_val = '0;

  always #5 CLK = ~CLK;

  ft245_cmd_rx #(.TIMEOUT_CYC(TO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXF      (RXF),
    .DATA_IN  (DATA_IN),
    .RD       (RD),
    .BUS_GNT  (BUS_GNT),
    .BUS_BUSY (BUS_BUSY),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_ADDR (CMD_ADDR),
    .CMD_DATA (CMD_DATA),
    .ERR_CNT  (ERR_CNT)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void drive_bus();
    RXF     = (host_q.size() == 0);
    DATA_IN = (host_q.size() != 0) ? host_q[0] : 8'h00;
  endfunction

  // reference: frame the byte stream at packet level
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] x;
    if (m_pkt.size() == 0 && b != 8'hA5) return;
    m_pkt.push_back(b);
    if (m_pkt.size() == PLEN) begin
      x = m_pkt[1] ^ m_pkt[2] ^ m_pkt[3] ^ m_pkt[4] ^ m_pkt[5];
`ifdef CMD_RX_CHECKSUM_EN
      if (m_pkt[6] == x)
        exp_q.push_back({m_pkt[1], m_pkt[2], m_pkt[3], m_pkt[4], m_pkt[5]});
      else
        m_err++;
`else
      if (x == x)
        exp_q.push_back({m_pkt[1], m_pkt[2], m_pkt[3], m_pkt[4], m_pkt[5]});
`endif
      m_pkt.delete();
    end
  endfunction

  function automatic void model_timeout();
    m_pkt.delete();
    m_err++;
  endfunction

  task automatic host_push(input logic [7:0] b);
    host_q.push_back(b);
    model_byte(b);
    drive_bus();
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [31:0] d);
    host_push(8'hA5);
    host_push(a);
    host_push(d[31:24]);
    host_push(d[23:16]);
    host_push(d[15:8]);
    host_push(d[7:0]);
`ifdef CMD_RX_CHECKSUM_EN
    host_push(a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while ((host_q.size() != 0 || exp_q.size() != 0 ||
            CMD_VALID === 1'b1) && i < budget) begin
      @(negedge CLK);
      i++;
    end
    chk({tag, "_drained"}, 64'(i < budget), 64'd1);
    repeat (10) @(negedge CLK);
  endtask

  // FT245 side: one byte consumed per RD# strobe
  always @(negedge RD) begin
    in_rd = 1'b1;
    n_reads++;
    chk("rd_only_when_rxf", 64'(host_q.size() != 0), 64'd1);
  end

  always @(posedge RD) begin
    if (in_rd) begin
      in_rd = 1'b0;
      if (host_q.size() != 0) void'(host_q.pop_front());
      drive_bus();
    end
  end

  always @(posedge CLK) begin
    #1;
    CMD_READY = rnd_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // consumer: compare every accepted command, check hold stability
  always @(negedge CLK) begin
    if (RST === 1'b1 && CMD_VALID === 1'b1) begin
      if (!hold_seen) begin
        hold_seen = 1'b1;
        hold_val  = {CMD_ADDR, CMD_DATA};
      end else begin
        chk("hold_stable", 64'({CMD_ADDR, CMD_DATA}), 64'(hold_val));
      end
      if (CMD_READY === 1'b1) begin
        hold_seen = 1'b0;
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_cmd: observed %0h expected none",
                 {CMD_ADDR, CMD_DATA});
        end
        if (exp_q.size() != 0)
          chk("cmd", 64'({CMD_ADDR, CMD_DATA}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int i;
    int cnt;
    int snap;
    logic fell;
    logic [7:0] b;
    logic [31:0] d;

    RST = 1'b0;
    BUS_GNT = 1'b1;
    drive_bus();
    repeat (3) @(negedge CLK);
    chk("rst_rd", 64'(RD), 64'd1);
    chk("rst_busy", 64'(BUS_BUSY), 64'd0);
    chk("rst_valid", 64'(CMD_VALID), 64'd0);
    chk("rst_addr", 64'(CMD_ADDR), 64'd0);
    chk("rst_data", 64'(CMD_DATA), 64'd0);
    chk("rst_err", 64'(ERR_CNT), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // basic packet
    send_pkt(8'h10, 32'h12345678);
    wait_idle("t1", 400);
    chk("t1_err", 64'(ERR_CNT), 64'(m_err));

    // leading garbage, sync value inside payload
    host_push(8'h00);
    host_push(8'hFF);
    host_push(8'hA4);
    send_pkt(8'h21, 32'hA5A5F00D);
    wait_idle("t2", 600);
    chk("t2_err", 64'(ERR_CNT), 64'd0);

`ifdef CMD_RX_CHECKSUM_EN
    // corrupted checksum then a good packet
    host_push(8'hA5);
    host_push(8'h10);
    host_push(8'h12);
    host_push(8'h34);
    host_push(8'h56);
    host_push(8'h78);
    host_push(8'h10 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h01);
    send_pkt(8'h33, 32'h0BADBEEF);
    wait_idle("t3", 600);
    chk("t3_err", 64'(ERR_CNT), 64'd1);
`endif

    // backpressure with a second packet queued
    ready_lvl = 1'b0;
    send_pkt(8'h44, 32'hDEADBEEF);
    send_pkt(8'h55, 32'h01020304);
    i = 0;
    while (CMD_VALID !== 1'b1 && i < 300) begin
      @(negedge CLK);
      i++;
    end
    chk("t4_valid", 64'(CMD_VALID), 64'd1);
    snap = n_reads;
    repeat (100) @(negedge CLK);
    chk("t4_no_read", 64'(n_reads - snap), 64'd0);
    chk("t4_rd_high", 64'(RD), 64'd1);
    chk("t4_rxf_low", 64'(RXF), 64'd0);
    chk("t4_addr", 64'(CMD_ADDR), 64'h44);
    ready_lvl = 1'b1;
    wait_idle("t4", 600);

    // stalled host mid-packet
    host_push(8'hA5);
    host_push(8'h10);
    host_push(8'h12);
    model_timeout();
    i = 0;
    while (host_q.size() != 0 && i < 100) begin
      @(negedge CLK);
      i++;
    end
    chk("t5_bytes_read", 64'(host_q.size()), 64'd0);
    repeat (TO - 20) @(negedge CLK);
    chk("t5_err_early", 64'(ERR_CNT), 64'(m_err - 1));
    repeat (30) @(negedge CLK);
    chk("t5_err", 64'(ERR_CNT), 64'(m_err));
    send_pkt(8'h66, 32'hCAFE0001);
    wait_idle("t5", 400);

    // bus grant gating
    BUS_GNT = 1'b0;
    send_pkt(8'h77, 32'h89ABCDEF);
    snap = n_reads;
    repeat (50) @(negedge CLK);
    chk("t6_no_read", 64'(n_reads - snap), 64'd0);
    @(posedge CLK); #1;
    BUS_GNT = 1'b1;
    fell = 1'b0;
    for (int k = 0; k < 3 && !fell; k++) begin
      @(negedge CLK);
      fell = (RD === 1'b0);
    end
    chk("t6_rd_fall", 64'(fell), 64'd1);
    chk("t6_busy", 64'(BUS_BUSY), 64'd1);
    cnt = 0;
    while (RD === 1'b0 && cnt < 20) begin
      cnt++;
      @(negedge CLK);
    end
    chk("t6_pulse_len", 64'(cnt), 64'd4);
    wait_idle("t6", 400);

    // randomized traffic with random consumer stalls
    rnd_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cnt = $urandom_range(0, 3);
      for (int g = 0; g < cnt; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        host_push(b);
      end
      d = $urandom;
      send_pkt(8'($urandom_range(0, 255)), d);
    end
    wait_idle("t7", 4000);
    chk("t7_err", 64'(ERR_CNT), 64'(m_err));
    chk("t7_valid_low", 64'(CMD_VALID), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
